// File: rtl/usrt_rx_ctrl_pkg.sv
// Shared constants for the USRT receive path: frame layout, parity modes,
// controller state encodings and the frame parity check.
package usrt_rx_ctrl_pkg;
  localparam int FRAME_W  = 11;
  localparam int BAUD_W   = 14;

  localparam int START_B  = 0;
  localparam int DATA_LSB = 1;
  localparam int PAR_B    = 9;
  localparam int STOP_B   = 10;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  function automatic logic parity_ok(input logic [FRAME_W-1:0] f, input int mode);
    logic x;
    x = ^f[DATA_LSB +: 8];
    case (mode)
      PAR_EVEN: return f[PAR_B] == x;
      PAR_ODD:  return f[PAR_B] == ~x;
      default:  return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/usrt_rx_ctrl_if.sv
// Host / rxshift / baudgen side signals of the USRT receive controller.
interface usrt_rx_ctrl_if #(parameter int DEPTH = 4);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          i_Baud_Wr;
  logic [13:0]   i_Baud_Div;
  logic [13:0]   o_Baud;
  logic          i_Rx_Serial;
  logic [10:0]   i_Frame;
  logic          i_Frame_Done;
  logic [7:0]    o_Rx_Data;
  logic          o_Rx_Valid;
  logic          i_Rx_Ready;
  logic [LW-1:0] o_Level;
  logic          o_Busy;
  logic          o_Frame_Err;
  logic          o_Parity_Err;
  logic          o_Overrun;
  logic          i_Err_Clr;

  modport master (
    output i_Baud_Wr, i_Baud_Div, i_Rx_Serial, i_Frame, i_Frame_Done, i_Rx_Ready, i_Err_Clr,
    input  o_Baud, o_Rx_Data, o_Rx_Valid, o_Level, o_Busy, o_Frame_Err, o_Parity_Err, o_Overrun
  );
  modport slave (
    input  i_Baud_Wr, i_Baud_Div, i_Rx_Serial, i_Frame, i_Frame_Done, i_Rx_Ready, i_Err_Clr,
    output o_Baud, o_Rx_Data, o_Rx_Valid, o_Level, o_Busy, o_Frame_Err, o_Parity_Err, o_Overrun
  );
endinterface

// File: rtl/usrt_rx_fifo.sv
// Small byte FIFO with occupancy count; shared with the TX path.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module usrt_rx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
)(
  input  logic                       gclk,
  input  logic                       grst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign empty   = level == '0;
  assign full    = level == FULL_LVL;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/usrt_rx_ctrl.sv
// USRT receive controller: frames start edge to rxshift done, checks start/stop/parity,
// queues good bytes for the host and owns the baudgen divisor.
module usrt_rx_ctrl
  import usrt_rx_ctrl_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int PARITY      = PAR_EVEN,
  parameter int TIMEOUT_CYC = 4096,
  parameter int BAUD_RST    = 87
)(
  input  logic          i_Pclk,
  input  logic          i_Rst_n,
  usrt_rx_ctrl_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic               rx_s1, rx_s2, rx_prev, done_d;
  logic [1:0]         state;
  logic [TW-1:0]      cnt;
  logic [FRAME_W-1:0] frame_q;
  logic               push_q;
  logic               pend_v;
  logic [BAUD_W-1:0]  pend;
  logic               fifo_full, fifo_empty, pop;
  logic [LW-1:0]      level;
  logic               line_fall, done_rise, tmo, in_check, hdr_ok, par_ok;
  logic               chk_ferr, chk_perr, chk_good, ovr_evt;

  assign line_fall = rx_prev & ~rx_s2;
  assign done_rise = bus.i_Frame_Done & ~done_d;
  // a done edge in the last timeout cycle still completes the frame
  assign tmo       = (state == ST_RECV) & ~done_rise & (cnt == TMO_LAST);
  assign in_check  = state == ST_CHECK;
  assign hdr_ok    = ~frame_q[START_B] & frame_q[STOP_B];
  assign par_ok    = parity_ok(frame_q, PARITY);
  assign chk_ferr  = in_check & ~hdr_ok;
  assign chk_perr  = in_check & hdr_ok & ~par_ok;
  assign chk_good  = in_check & hdr_ok & par_ok;
  assign pop       = ~fifo_empty & bus.i_Rx_Ready;
  assign ovr_evt   = push_q & fifo_full & ~pop;

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      done_d  <= 1'b0;
    end else begin
      rx_s1   <= bus.i_Rx_Serial;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      done_d  <= bus.i_Frame_Done;
    end
  end

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      frame_q <= '0;
      push_q  <= 1'b0;
    end else begin
      push_q <= chk_good;
      case (state)
        ST_IDLE: if (line_fall) begin
          state <= ST_RECV;
          cnt   <= '0;
        end
        ST_RECV: begin
          if (done_rise) begin
            state   <= ST_CHECK;
            frame_q <= bus.i_Frame;
          end else if (tmo) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // sticky flags: a new event in the clear cycle survives the clear
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bus.o_Frame_Err  <= 1'b0;
      bus.o_Parity_Err <= 1'b0;
      bus.o_Overrun    <= 1'b0;
    end else begin
      bus.o_Frame_Err  <= (bus.o_Frame_Err  & ~bus.i_Err_Clr) | chk_ferr | tmo;
      bus.o_Parity_Err <= (bus.o_Parity_Err & ~bus.i_Err_Clr) | chk_perr;
      bus.o_Overrun    <= (bus.o_Overrun    & ~bus.i_Err_Clr) | ovr_evt;
    end
  end

  // divisor changes land only while no frame is in flight
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bus.o_Baud <= BAUD_W'(BAUD_RST);
      pend       <= '0;
      pend_v     <= 1'b0;
    end else begin
      if (state == ST_IDLE && pend_v) bus.o_Baud <= pend;
      if (bus.i_Baud_Wr && bus.i_Baud_Div != '0) begin
        pend   <= bus.i_Baud_Div;
        pend_v <= 1'b1;
      end else if (state == ST_IDLE) begin
        pend_v <= 1'b0;
      end
    end
  end

  usrt_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_fifo (
    .gclk   (i_Pclk),
    .grst_n (i_Rst_n),
    .push   (push_q),
    .pop    (pop),
    .din    (frame_q[DATA_LSB +: 8]),
    .dout   (bus.o_Rx_Data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  assign bus.o_Rx_Valid = ~fifo_empty;
  assign bus.o_Level    = level;
  assign bus.o_Busy     = state != ST_IDLE;
endmodule

// File: tb/tb_usrt_rx_ctrl.sv
// Bench for usrt_rx_ctrl: directed scenarios plus randomized frames, all checked
// each cycle against an event-scheduled model of the receive rules.
module tb_usrt_rx_ctrl;
  localparam int DEPTH    = 4;
  localparam int PARITY   = 1;
  localparam int TMO      = 4096;
  localparam int BAUD_RST = 87;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #50 clk = ~clk;

  usrt_rx_ctrl_if #(.DEPTH(DEPTH)) bif();

  usrt_rx_ctrl #(.DEPTH(DEPTH), .PARITY(PARITY), .TIMEOUT_CYC(TMO), .BAUD_RST(BAUD_RST)) dut (
    .i_Pclk  (clk),
    .i_Rst_n (rst_n),
    .bus     (bif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;
  logic rnd = 1'b0;
  int rdy_pct = 70;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  logic        m_busy = 0, m_check = 0, push_pend = 0;
  int          ec = 0, m_start = 0, verdict_at = 0, push_at = 0;
  logic [10:0] m_frame = '0;
  logic [7:0]  push_val = '0;
  logic        m_fe = 0, m_pe = 0, m_ov = 0;
  logic [13:0] m_baud = 14'(BAUD_RST), m_pend = '0;
  logic        m_pend_v = 0;
  logic        p1 = 1, p2 = 1, p3 = 1, m_dprev = 0;

  // 0 good, 1 framing error, 2 parity error
  function automatic int verdict(input logic [10:0] f);
    int ones = 0;
    if (f[0] !== 1'b0 || f[10] !== 1'b1) return 1;
    for (int i = 1; i <= 8; i++) ones += int'(f[i]);
    if (PARITY == 1 && f[9] != 1'((ones % 2))) return 2;
    if (PARITY == 2 && f[9] == 1'((ones % 2))) return 2;
    return 0;
  endfunction

  function automatic logic [10:0] mkframe(input logic [7:0] d, input logic pflip,
                                          input logic bad_start, input logic bad_stop);
    logic p = 1'b0;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    if (PARITY == 2) p = ~p;
    return {~bad_stop, p ^ pflip, d, bad_start};
  endfunction

  always @(posedge clk) begin : model
    logic fall, drise, was_idle, pop, push, fe_s, pe_s, ov_s;
    int v;
    if (!rst_n) begin
      mq.delete();
      m_busy = 0; m_check = 0; push_pend = 0;
      m_fe = 0; m_pe = 0; m_ov = 0;
      m_baud = 14'(BAUD_RST); m_pend_v = 0;
      p1 = 1; p2 = 1; p3 = 1; m_dprev = 0;
    end else begin
      ec++;
      fall = !p2 && p3;
      drise = bif.i_Frame_Done && !m_dprev;
      was_idle = !m_busy;
      fe_s = 0; pe_s = 0; ov_s = 0; push = 0;
      pop = (mq.size() != 0) && bif.i_Rx_Ready;
      if (push_pend && ec == push_at) begin
        push_pend = 0;
        if (mq.size() < DEPTH || pop) push = 1;
        else ov_s = 1;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(push_val);
      if (m_busy) begin
        if (m_check) begin
          if (ec == verdict_at) begin
            m_busy = 0; m_check = 0;
            v = verdict(m_frame);
            if (v == 1) fe_s = 1;
            else if (v == 2) pe_s = 1;
            else begin push_pend = 1; push_at = ec + 1; push_val = m_frame[8:1]; end
          end
        end else if (drise) begin
          m_check = 1; verdict_at = ec + 1; m_frame = bif.i_Frame;
        end else if (ec - m_start == TMO) begin
          m_busy = 0; fe_s = 1;
        end
      end else if (fall) begin
        m_busy = 1; m_start = ec;
      end
      if (was_idle && m_pend_v) begin m_baud = m_pend; m_pend_v = 0; end
      if (bif.i_Baud_Wr && bif.i_Baud_Div != 0) begin m_pend = bif.i_Baud_Div; m_pend_v = 1; end
      if (bif.i_Err_Clr) begin m_fe = 0; m_pe = 0; m_ov = 0; end
      m_fe = m_fe | fe_s; m_pe = m_pe | pe_s; m_ov = m_ov | ov_s;
      p3 = p2; p2 = p1; p1 = bif.i_Rx_Serial; m_dprev = bif.i_Frame_Done;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("valid", bif.o_Rx_Valid, mq.size() != 0);
      if (mq.size() != 0) chk("data", bif.o_Rx_Data, mq[0]);
      chk("level", bif.o_Level, mq.size());
      chk("busy", bif.o_Busy, m_busy);
      chk("frame_err", bif.o_Frame_Err, m_fe);
      chk("parity_err", bif.o_Parity_Err, m_pe);
      chk("overrun", bif.o_Overrun, m_ov);
      chk("baud", bif.o_Baud, m_baud);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
    if (rnd) begin
      bif.i_Rx_Ready = ($urandom % 100) < rdy_pct;
      bif.i_Err_Clr  = ($urandom % 40) == 0;
      bif.i_Baud_Wr  = ($urandom % 60) == 0;
      bif.i_Baud_Div = ($urandom % 4 == 0) ? 14'd0 : 14'($urandom);
    end else begin
      bif.i_Err_Clr = 1'b0;
      bif.i_Baud_Wr = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic serial(input logic [10:0] f, input int bp);
    for (int i = 0; i < 11; i++) begin
      bif.i_Rx_Serial = f[i];
      ticks(bp);
    end
    bif.i_Rx_Serial = 1'b1;
  endtask

  task automatic send(input logic [10:0] f, input int bp, input int dl);
    serial(f, bp);
    bif.i_Frame = f;
    bif.i_Frame_Done = 1'b1;
    ticks(dl);
    bif.i_Frame_Done = 1'b0;
    ticks(5);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_valid"}, bif.o_Rx_Valid, 0);
    chk({tag, "_level"}, bif.o_Level, 0);
    chk({tag, "_data"},  bif.o_Rx_Data, 0);
    chk({tag, "_busy"},  bif.o_Busy, 0);
    chk({tag, "_flags"}, {bif.o_Frame_Err, bif.o_Parity_Err, bif.o_Overrun}, 0);
    chk({tag, "_baud"},  bif.o_Baud, 87);
  endtask

  logic [7:0]  d6[6];
  logic [10:0] f;
  int lat;

  initial begin
    bif.i_Rx_Serial = 1; bif.i_Frame = '0; bif.i_Frame_Done = 0; bif.i_Rx_Ready = 0;
    bif.i_Err_Clr = 0; bif.i_Baud_Wr = 0; bif.i_Baud_Div = '0;
    ticks(3);
    @(negedge clk); reset_vals("rst");
    tick(); rst_n = 1'b1; cmp_en = 1'b1;
    ticks(4);

    // good frame 0x8D and its push latency
    f = mkframe(8'h8D, 0, 0, 0);
    chk("frame_8D", f, 11'b10100011010);
    serial(f, 2);
    bif.i_Frame = f; bif.i_Frame_Done = 1'b1;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      bif.i_Frame_Done = 1'b0;
      if (bif.o_Rx_Valid && lat == 0) lat = k;
    end
    chk("latency", lat, 3);
    @(negedge clk);
    chk("t1_data", bif.o_Rx_Data, 8'h8D);
    chk("t1_level", bif.o_Level, 1);
    chk("t1_flags", {bif.o_Frame_Err, bif.o_Parity_Err, bif.o_Overrun}, 0);
    bif.i_Rx_Ready = 1; tick(); bif.i_Rx_Ready = 0; ticks(2);

    // parity error, then clear
    send(mkframe(8'h8D, 1, 0, 0), 2, 1);
    @(negedge clk);
    chk("t2_perr", bif.o_Parity_Err, 1);
    chk("t2_valid", bif.o_Rx_Valid, 0);
    bif.i_Err_Clr = 1; tick(); @(negedge clk);
    chk("t2_clr", bif.o_Parity_Err, 0);

    // bad stop bit, then line stuck low
    send(mkframe(8'h8D, 0, 0, 1), 2, 1);
    @(negedge clk);
    chk("t3_ferr", bif.o_Frame_Err, 1);
    chk("t3_level", bif.o_Level, 0);
    bif.i_Err_Clr = 1; tick();
    bif.i_Rx_Serial = 0; ticks(TMO - 10);
    @(negedge clk);
    chk("t3_busy_pre", bif.o_Busy, 1);
    chk("t3_ferr_pre", bif.o_Frame_Err, 0);
    ticks(20); @(negedge clk);
    chk("t3_busy_tmo", bif.o_Busy, 0);
    chk("t3_ferr_tmo", bif.o_Frame_Err, 1);
    bif.i_Rx_Serial = 1; bif.i_Err_Clr = 1; tick(); ticks(4);

    // overfill with host stalled
    for (int i = 0; i < 6; i++) begin
      d6[i] = 8'($urandom);
      send(mkframe(d6[i], 0, 0, 0), 1, 1);
    end
    @(negedge clk);
    chk("t4_level", bif.o_Level, 4);
    chk("t4_ovr", bif.o_Overrun, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t4_order", bif.o_Rx_Data, d6[i]);
      bif.i_Rx_Ready = 1; tick(); bif.i_Rx_Ready = 0;
    end
    bif.i_Err_Clr = 1; tick();
    for (int i = 0; i < 4; i++) send(mkframe(d6[i], 0, 0, 0), 1, 1);
    serial(mkframe(8'hA7, 0, 0, 0), 1);
    bif.i_Frame = mkframe(8'hA7, 0, 0, 0); bif.i_Frame_Done = 1;
    tick(); bif.i_Frame_Done = 0;
    tick(); bif.i_Rx_Ready = 1;
    tick(); bif.i_Rx_Ready = 0;
    ticks(3); @(negedge clk);
    chk("t4_full_ovr", bif.o_Overrun, 0);
    chk("t4_full_level", bif.o_Level, 4);
    chk("t4_full_head", bif.o_Rx_Data, d6[1]);
    bif.i_Rx_Ready = 1; ticks(6); bif.i_Rx_Ready = 0;

    // divisor write mid-frame, then a zero write
    bif.i_Rx_Serial = 0; ticks(4);
    bif.i_Baud_Div = 14'h2B; bif.i_Baud_Wr = 1; tick();
    ticks(3); @(negedge clk);
    chk("t5_busy", bif.o_Busy, 1);
    chk("t5_hold", bif.o_Baud, 87);
    bif.i_Rx_Serial = 1; bif.i_Frame = mkframe(8'h55, 0, 0, 0); bif.i_Frame_Done = 1;
    tick(); bif.i_Frame_Done = 0; ticks(4); @(negedge clk);
    chk("t5_apply", bif.o_Baud, 14'h2B);
    bif.i_Baud_Div = 14'd0; bif.i_Baud_Wr = 1; tick(); ticks(3); @(negedge clk);
    chk("t5_zero", bif.o_Baud, 14'h2B);

    // reset mid-frame with a byte queued
    bif.i_Rx_Serial = 0; ticks(5);
    rst_n = 1'b0; #10;
    reset_vals("t6");
    ticks(2); bif.i_Rx_Serial = 1; ticks(3);
    rst_n = 1'b1; ticks(4);
    send(mkframe(8'h3C, 0, 0, 0), 2, 2);
    @(negedge clk);
    chk("t6_data", bif.o_Rx_Data, 8'h3C);
    chk("t6_level", bif.o_Level, 1);
    bif.i_Rx_Ready = 1; tick(); bif.i_Rx_Ready = 0;

    // randomized frames and host behaviour
    rnd = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [7:0] d;
      int r;
      if (n % 50 == 0) rdy_pct = (n % 100 == 0) ? 20 : 80;
      d = 8'($urandom);
      r = int'($urandom % 16);
      f = mkframe(d, r == 0, r == 1, r == 2);
      serial(f, 1 + int'($urandom % 3));
      bif.i_Frame = f; bif.i_Frame_Done = 1;
      ticks(1 + int'($urandom % 3));
      bif.i_Frame_Done = 0;
      ticks(3 + int'($urandom % 6));
      if ($urandom % 10 == 0) begin
        bif.i_Frame = 11'($urandom); bif.i_Frame_Done = 1; tick();
        bif.i_Frame_Done = 0; ticks(3);
      end
    end
    rnd = 1'b0;
    bif.i_Rx_Ready = 1; ticks(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
